// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions: widths, ALU operation codes and the
// register-match helper used by forwarding and hazard detection.
package cpu_pkg;

    localparam int XLEN      = 32;
    localparam int REG_IDX_W = 5;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_SLT = 4'b0101;

    // A producer matches a source only when it writes a real register (x0 never matches).
    function automatic logic reg_hit(input logic                 wr_en,
                                     input logic [REG_IDX_W-1:0] rd,
                                     input logic [REG_IDX_W-1:0] idx);
        return wr_en && (rd != '0) && (rd == idx);
    endfunction

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Forwarding select for one ALU source: EX/MEM first, then MEM/WB,
// otherwise the register-file data captured by the ID/EX stage.
module fwd_mux
    import cpu_pkg::reg_hit;
#(
    parameter int XLEN      = 32,
    parameter int REG_IDX_W = 5
) (
    input  logic [REG_IDX_W-1:0] idx,
    input  logic [XLEN-1:0]      reg_data,
    input  logic [REG_IDX_W-1:0] exmem_rd,
    input  logic                 exmem_reg_write,
    input  logic [XLEN-1:0]      exmem_result,
    input  logic [REG_IDX_W-1:0] memwb_rd,
    input  logic                 memwb_reg_write,
    input  logic [XLEN-1:0]      memwb_result,
    output logic [XLEN-1:0]      fwd
);

    always_comb begin
        fwd = reg_data;
        if (reg_hit(exmem_reg_write, exmem_rd, idx))
            fwd = exmem_result;
        else if (reg_hit(memwb_reg_write, memwb_rd, idx))
            fwd = memwb_result;
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU, with operand forwarding,
// load-use bubble insertion, stall hold and flush.
module id_ex_stage #(
    parameter int XLEN      = 32,
    parameter int REG_IDX_W = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 in_valid,
    input  logic [REG_IDX_W-1:0] rs1_idx,
    input  logic [REG_IDX_W-1:0] rs2_idx,
    input  logic [REG_IDX_W-1:0] rd_idx,
    input  logic [XLEN-1:0]      rs1_data,
    input  logic [XLEN-1:0]      rs2_data,
    input  logic [XLEN-1:0]      imm,
    input  logic [3:0]           alu_op_in,
    input  logic                 alu_src_imm,
    input  logic                 reg_write_in,
    input  logic                 mem_read_in,
    input  logic                 mem_write_in,
    input  logic [REG_IDX_W-1:0] exmem_rd,
    input  logic                 exmem_reg_write,
    input  logic [XLEN-1:0]      exmem_result,
    input  logic [REG_IDX_W-1:0] memwb_rd,
    input  logic                 memwb_reg_write,
    input  logic [XLEN-1:0]      memwb_result,
    output logic [XLEN-1:0]      alu_a,
    output logic [XLEN-1:0]      alu_b,
    output logic [3:0]           alu_op,
    output logic [XLEN-1:0]      store_data,
    output logic [REG_IDX_W-1:0] rd_out,
    output logic                 reg_write_out,
    output logic                 mem_read_out,
    output logic                 mem_write_out,
    output logic                 valid_out,
    output logic                 load_use_stall
);

    import cpu_pkg::reg_hit;

    logic                 vld_p1;
    logic [REG_IDX_W-1:0] rs1_p1, rs2_p1, rd_p1;
    logic [XLEN-1:0]      rs1_data_p1, rs2_data_p1, imm_p1;
    logic [3:0]           alu_op_p1;
    logic                 alu_src_imm_p1, reg_write_p1, mem_read_p1, mem_write_p1;
    logic [XLEN-1:0]      fwd_a, fwd_b;

    // Conservative: any instruction reading the load's destination on either port waits a cycle.
    assign load_use_stall = in_valid &&
                            (reg_hit(vld_p1 && mem_read_p1, rd_p1, rs1_idx) ||
                             reg_hit(vld_p1 && mem_read_p1, rd_p1, rs2_idx));

    // ---- decode -> execute boundary ----
    always_ff @(posedge clk) begin
        if (rst || flush || (!stall && load_use_stall)) begin
            vld_p1         <= 1'b0;
            rs1_p1         <= '0;
            rs2_p1         <= '0;
            rd_p1          <= '0;
            rs1_data_p1    <= '0;
            rs2_data_p1    <= '0;
            imm_p1         <= '0;
            alu_op_p1      <= '0;
            alu_src_imm_p1 <= 1'b0;
            reg_write_p1   <= 1'b0;
            mem_read_p1    <= 1'b0;
            mem_write_p1   <= 1'b0;
        end else if (!stall) begin
            vld_p1         <= in_valid;
            rs1_p1         <= rs1_idx;
            rs2_p1         <= rs2_idx;
            rd_p1          <= rd_idx;
            rs1_data_p1    <= rs1_data;
            rs2_data_p1    <= rs2_data;
            imm_p1         <= imm;
            alu_op_p1      <= alu_op_in;
            alu_src_imm_p1 <= alu_src_imm;
            reg_write_p1   <= reg_write_in && in_valid;
            mem_read_p1    <= mem_read_in && in_valid;
            mem_write_p1   <= mem_write_in && in_valid;
        end
    end

    fwd_mux #(.XLEN(XLEN), .REG_IDX_W(REG_IDX_W)) u_fwd_a (
        .idx             (rs1_p1),
        .reg_data        (rs1_data_p1),
        .exmem_rd        (exmem_rd),
        .exmem_reg_write (exmem_reg_write),
        .exmem_result    (exmem_result),
        .memwb_rd        (memwb_rd),
        .memwb_reg_write (memwb_reg_write),
        .memwb_result    (memwb_result),
        .fwd             (fwd_a)
    );

    fwd_mux #(.XLEN(XLEN), .REG_IDX_W(REG_IDX_W)) u_fwd_b (
        .idx             (rs2_p1),
        .reg_data        (rs2_data_p1),
        .exmem_rd        (exmem_rd),
        .exmem_reg_write (exmem_reg_write),
        .exmem_result    (exmem_result),
        .memwb_rd        (memwb_rd),
        .memwb_reg_write (memwb_reg_write),
        .memwb_result    (memwb_result),
        .fwd             (fwd_b)
    );

    assign alu_a         = fwd_a;
    assign alu_b         = alu_src_imm_p1 ? imm_p1 : fwd_b;
    assign store_data    = fwd_b;
    assign alu_op        = alu_op_p1;
    assign rd_out        = rd_p1;
    assign reg_write_out = reg_write_p1;
    assign mem_read_out  = mem_read_p1;
    assign mem_write_out = mem_write_p1;
    assign valid_out     = vld_p1;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: expected outputs are queued as stimulus is
// applied and popped for comparison once the stage has produced them.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst, stall, flush, in_valid;
    logic [4:0]  rs1_idx, rs2_idx, rd_idx;
    logic [31:0] rs1_data, rs2_data, imm;
    logic [3:0]  alu_op_in;
    logic        alu_src_imm, reg_write_in, mem_read_in, mem_write_in;
    logic [4:0]  exmem_rd, memwb_rd;
    logic        exmem_reg_write, memwb_reg_write;
    logic [31:0] exmem_result, memwb_result;
    logic [31:0] alu_a, alu_b, store_data;
    logic [3:0]  alu_op;
    logic [4:0]  rd_out;
    logic        reg_write_out, mem_read_out, mem_write_out, valid_out, load_use_stall;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       tag;
        logic [31:0] a, b, sd;
        logic [3:0]  op;
        logic [4:0]  rd;
        logic        rw, mr, mw, vld, lus;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
        .rs1_idx(rs1_idx), .rs2_idx(rs2_idx), .rd_idx(rd_idx),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
        .alu_op_in(alu_op_in), .alu_src_imm(alu_src_imm),
        .reg_write_in(reg_write_in), .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
        .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write), .exmem_result(exmem_result),
        .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write), .memwb_result(memwb_result),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .store_data(store_data),
        .rd_out(rd_out), .reg_write_out(reg_write_out), .mem_read_out(mem_read_out),
        .mem_write_out(mem_write_out), .valid_out(valid_out), .load_use_stall(load_use_stall)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] sd, input logic [3:0] op, input logic [4:0] rd,
                              input logic rw, input logic mr, input logic mw,
                              input logic vld, input logic lus);
        exp_t e;
        e.tag = tag; e.a = a; e.b = b; e.sd = sd; e.op = op; e.rd = rd;
        e.rw = rw; e.mr = mr; e.mw = mw; e.vld = vld; e.lus = lus;
        sb.push_back(e);
    endtask

    task automatic compare_out();
        exp_t e;
        total++;
        assert (sb.size() > 0) else begin
            bad++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
            return;
        end
        e = sb.pop_front();
        chk({e.tag, "/alu_a"},      alu_a,          e.a);
        chk({e.tag, "/alu_b"},      alu_b,          e.b);
        chk({e.tag, "/store_data"}, store_data,     e.sd);
        chk({e.tag, "/alu_op"},     32'(alu_op),    32'(e.op));
        chk({e.tag, "/rd_out"},     32'(rd_out),    32'(e.rd));
        chk({e.tag, "/reg_write"},  32'(reg_write_out), 32'(e.rw));
        chk({e.tag, "/mem_read"},   32'(mem_read_out),  32'(e.mr));
        chk({e.tag, "/mem_write"},  32'(mem_write_out), 32'(e.mw));
        chk({e.tag, "/valid"},      32'(valid_out),     32'(e.vld));
        chk({e.tag, "/lus"},        32'(load_use_stall), 32'(e.lus));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic decode(input logic v, input logic [4:0] r1, input logic [31:0] d1,
                          input logic [4:0] r2, input logic [31:0] d2, input logic [4:0] rd,
                          input logic [31:0] im, input logic [3:0] op, input logic simm,
                          input logic rw, input logic mr, input logic mw);
        in_valid = v; rs1_idx = r1; rs1_data = d1; rs2_idx = r2; rs2_data = d2;
        rd_idx = rd; imm = im; alu_op_in = op; alu_src_imm = simm;
        reg_write_in = rw; mem_read_in = mr; mem_write_in = mw;
    endtask

    task automatic fwd(input logic ew, input logic [4:0] erd, input logic [31:0] eres,
                       input logic mw, input logic [4:0] mrd, input logic [31:0] mres);
        exmem_reg_write = ew; exmem_rd = erd; exmem_result = eres;
        memwb_reg_write = mw; memwb_rd = mrd; memwb_result = mres;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        decode(1'b0, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

        // Reset clears everything
        tick();
        tick();
        expect_out("reset", 0, 0, 0, 4'h0, 5'd0, 0, 0, 0, 0, 0);
        compare_out();

        // Plain pass-through of a sub
        rst = 1'b0;
        decode(1'b1, 5'd1, 32'd5, 5'd2, 32'd3, 5'd3, 32'd0, 4'b0001, 1'b0, 1'b1, 1'b0, 1'b0);
        expect_out("pass", 32'd5, 32'd3, 32'd3, 4'b0001, 5'd3, 1, 0, 0, 1, 0);
        tick();
        compare_out();

        // Forwarding priority on source A
        decode(1'b1, 5'd7, 32'h11, 5'd8, 32'h22, 5'd9, 32'd0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        fwd(1'b1, 5'd7, 32'hAA, 1'b1, 5'd7, 32'hBB);
        expect_out("fwd_exmem", 32'hAA, 32'h22, 32'h22, 4'h0, 5'd9, 1, 0, 0, 1, 0);
        #1 compare_out();
        exmem_reg_write = 1'b0;
        expect_out("fwd_memwb", 32'hBB, 32'h22, 32'h22, 4'h0, 5'd9, 1, 0, 0, 1, 0);
        #1 compare_out();
        exmem_reg_write = 1'b1; exmem_rd = 5'd0; memwb_rd = 5'd0;
        expect_out("fwd_x0", 32'h11, 32'h22, 32'h22, 4'h0, 5'd9, 1, 0, 0, 1, 0);
        #1 compare_out();

        // Immediate select with rs2 forwarded for the store path
        decode(1'b1, 5'd1, 32'd1, 5'd5, 32'h55, 5'd6, 32'hFFFF_FFFC, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0);
        fwd(1'b1, 5'd5, 32'h10, 1'b0, 5'd0, 32'd0);
        expect_out("imm", 32'd1, 32'hFFFF_FFFC, 32'h10, 4'h0, 5'd6, 1, 0, 0, 1, 0);
        tick();
        compare_out();

        // Load-use: lw x4, then an add reading x4
        decode(1'b1, 5'd1, 32'h100, 5'd0, 32'd0, 5'd4, 32'd8, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0);
        fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        expect_out("lw", 32'h100, 32'd8, 32'd0, 4'h0, 5'd4, 1, 1, 0, 1, 0);
        tick();
        compare_out();
        decode(1'b1, 5'd4, 32'd0, 5'd2, 32'd7, 5'd10, 32'd0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
        expect_out("lu_detect", 32'h100, 32'd8, 32'd0, 4'h0, 5'd4, 1, 1, 0, 1, 1);
        #1 compare_out();
        expect_out("lu_bubble", 0, 0, 0, 4'h0, 5'd0, 0, 0, 0, 0, 0);
        tick();
        compare_out();
        fwd(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'hDEAD);
        expect_out("lu_reissue", 32'hDEAD, 32'd7, 32'd7, 4'h0, 5'd10, 1, 0, 0, 1, 0);
        tick();
        compare_out();

        // Stall holds for three cycles while decode changes underneath
        stall = 1'b1;
        decode(1'b1, 5'd3, 32'h999, 5'd3, 32'h999, 5'd11, 32'd1, 4'b0011, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            expect_out("stall_hold", 32'hDEAD, 32'd7, 32'd7, 4'h0, 5'd10, 1, 0, 0, 1, 0);
            tick();
            compare_out();
        end
        flush = 1'b1;
        expect_out("stall_flush", 0, 0, 0, 4'h0, 5'd0, 0, 0, 0, 0, 0);
        tick();
        compare_out();
        stall = 1'b0; flush = 1'b0;

        // Reset while a load-use hazard is pending
        decode(1'b1, 5'd1, 32'h100, 5'd0, 32'd0, 5'd4, 32'd8, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0);
        fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        expect_out("lw2", 32'h100, 32'd8, 32'd0, 4'h0, 5'd4, 1, 1, 0, 1, 0);
        tick();
        compare_out();
        decode(1'b1, 5'd2, 32'd0, 5'd4, 32'd0, 5'd12, 32'd0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
        expect_out("lu_detect_rs2", 32'h100, 32'd8, 32'd0, 4'h0, 5'd4, 1, 1, 0, 1, 1);
        #1 compare_out();
        rst = 1'b1;
        expect_out("rst_hazard", 0, 0, 0, 4'h0, 5'd0, 0, 0, 0, 0, 0);
        tick();
        compare_out();
        rst = 1'b0;

        // Invalid slot: data captured, control gated off
        decode(1'b0, 5'd3, 32'h33, 5'd2, 32'd7, 5'd10, 32'd0, 4'b0101, 1'b0, 1'b1, 1'b1, 1'b1);
        expect_out("invalid_gate", 32'h33, 32'd7, 32'd7, 4'b0101, 5'd10, 0, 0, 0, 0, 0);
        tick();
        compare_out();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
ID/EX pipeline stage directly upstream of the ALU. Registers decoded operands and control from decode, resolves EX/MEM and MEM/WB forwarding, and drives the ALU's a, b and op inputs. Detects load-use hazards and inserts bubbles. Supports external stall and flush.

Parameters:
XLEN, 32, datapath width; must match the ALU's 32-bit a/b.
REG_IDX_W, 5, register index width.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  synchronous, active-high reset.
stall  in  1  downstream stall; hold all stage registers.
flush  in  1  branch/jump flush; load a bubble.
in_valid  in  1  the decode slot holds a real instruction.
rs1_idx, rs2_idx, rd_idx  in  REG_IDX_W  source and destination indices.
rs1_data, rs2_data  in  XLEN  register-file read data.
imm  in  XLEN  sign-extended immediate.
alu_op_in  in  4  ALU operation code.
alu_src_imm  in  1  selects imm (not rs2) as operand b.
reg_write_in, mem_read_in, mem_write_in  in  1  control bits.
exmem_rd  in  REG_IDX_W; exmem_reg_write  in  1; exmem_result  in  XLEN  EX/MEM forwarding source.
memwb_rd  in  REG_IDX_W; memwb_reg_write  in  1; memwb_result  in  XLEN  MEM/WB forwarding source.
alu_a, alu_b  out  XLEN  ALU operands.
alu_op  out  4  ALU operation.
store_data  out  XLEN  forwarded rs2 value, for stores.
rd_out  out  REG_IDX_W; reg_write_out, mem_read_out, mem_write_out, valid_out  out  1.
load_use_stall  out  1  tells fetch/decode to hold for one cycle.

Behaviour:
- Reset (synchronous, active-high): every stage register clears to 0, so valid_out=0, alu_op=4'b0000, all enables=0 and all data=0. Reset wins over every other input.
- Register update priority on each edge: rst > flush > stall > load_use_stall > normal load.
  - flush: load a bubble. valid=0; reg_write, mem_read and mem_write=0; data and indices cleared to 0.
  - stall (no flush): hold every register unchanged.
  - load_use_stall (no flush, no stall): load a bubble, same as flush. Upstream holds its instruction, so the instruction is re-presented next cycle.
  - Normal load: capture all inputs. valid_q=in_valid; the control bits are ANDed with in_valid.
- load_use_stall is combinational: valid_q & mem_read_q & (rd_q!=0) & in_valid & (rd_q==rs1_idx | rd_q==rs2_idx). It compares conservatively on both sources, whatever the instruction format.
- Forwarding is combinational and evaluated per source independently on the registered index (rs1_q or rs2_q):
  1. If exmem_reg_write & exmem_rd!=0 & exmem_rd==idx, use exmem_result.
  2. Else if memwb_reg_write & memwb_rd!=0 & memwb_rd==idx, use memwb_result.
  3. Else use the registered read data.
  - EX/MEM has priority when both stages match. x0 is never forwarded.
- alu_a = fwd_a. alu_b = alu_src_imm_q ? imm_q : fwd_b. store_data = fwd_b always.
- alu_op = alu_op_q, passed unmodified. Codes outside {0000 add, 0001 sub, 0010 and, 0011 or, 0101 slt} are passed through, and the ALU yields 0 for them.
- Latency: 1 cycle from decode inputs to registered outputs. The forwarding path has 0 cycles of latency.
- While valid_out=0, the data outputs are still driven; downstream must qualify them with the enables.
- Reset mid-stall clears the stage, and load_use_stall drops the same cycle, since valid_q=0.

Decomposition:
- Shared package (cpu_pkg): XLEN, REG_IDX_W, and ALU op constants ALU_ADD=4'b0000, ALU_SUB=4'b0001, ALU_AND=4'b0010, ALU_OR=4'b0011, ALU_SLT=4'b0101.
- Sub-module fwd_mux: 3:1 forwarding select for one source. Inputs are idx, reg data and both forwarding triples; output is the forwarded value. Instantiated twice, for A and B.

Test Plan:
1. Reset and pass-through: assert rst for 2 cycles, then load rs1_data=5, rs2_data=3, alu_op_in=0001, alu_src_imm=0, in_valid=1 with no forwarding matches -> after rst, all outputs are 0; one edge after the load, alu_a=5, alu_b=3, alu_op=0001, valid_out=1.
2. Forwarding priority: registered rs1=x7; exmem_rd=7 with result 0xAA and write=1; memwb_rd=7 with result 0xBB and write=1 -> alu_a=0xAA. Drop exmem_reg_write -> alu_a=0xBB. Set both rd=0 -> alu_a = register data.
3. Immediate select: alu_src_imm=1, imm=0xFFFFFFFC, rs2 forwarded from EX/MEM as 0x10 -> alu_b=0xFFFFFFFC, store_data=0x10.
4. Load-use: EX holds an lw to x4; decode presents an add reading x4 -> load_use_stall=1 that cycle; next cycle valid_out=0 with enables 0. On the following edge the add loads, and x4 is later forwarded from MEM/WB.
5. Stall vs flush: hold stall=1 for 3 cycles -> outputs unchanged. Assert stall=1 and flush=1 together -> bubble loaded (flush wins); valid_out=0, reg_write_out=0.
6. Reset mid-hazard: while load_use_stall=1, assert rst -> next edge valid_out=0, and load_use_stall=0 in the same cycle.
